// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART TX scheduler slice.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned UART_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RELEASE,
    ST_ACK
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              parity;
  } tx_word_t;

  // Parity over one data byte; odd=1 inverts the even result.
  function automatic logic calc_parity(input logic [BYTE_W-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Link between the scheduler and the parallel-to-serial TX stage.
interface uart_tx_sched_if;

  logic       tx_send;
  logic [7:0] tx_data;
  logic       tx_parity;
  logic       tx_done;

  modport master (output tx_send, output tx_data, output tx_parity, input tx_done);
  modport slave  (input tx_send, input tx_data, input tx_parity, output tx_done);

endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: search upward from ptr_i+1 with wrap.
module uart_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] win_id_c,
  output logic                       any_c
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    int idx;
    win_id_c = '0;
    any_c    = 1'b0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % int'(NUM_REQ);
      if (req_i[IDW'(idx)]) begin
        win_id_c = IDW'(idx);
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX stage among NUM_REQ byte producers.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter bit          PARITY_ODD  = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                       baud_clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       req_err,
  uart_tx_sched_if.master            tx,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy
);

  import uart_pkg::*;

  localparam int unsigned IDW   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic               tx_send_q, tx_send_d;
  tx_word_t           word_q, word_d;
  logic [IDW-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [BYTE_W-1:0]  req_byte [NUM_REQ];
  logic [IDW-1:0]     win_id_c;
  logic               any_valid_c;

  // Unpack the flat producer bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  uart_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .win_id_c (win_id_c),
    .any_c    (any_valid_c)
  );

  // State and datapath registers; reset drops tx_send immediately.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_send_q <= 1'b0;
      word_q    <= '0;
      gnt_q     <= '0;
      ptr_q     <= IDW'(NUM_REQ - 1);
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_send_q <= tx_send_d;
      word_q    <= word_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; ack/err are loaded on entry to ACK so they are high only there.
  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    word_d    = word_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    ack_d     = '0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A done left over from before reset blocks a new grant.
        if (!tx.tx_done && any_valid_c) begin
          word_d.data   = req_byte[win_id_c];
          word_d.parity = calc_parity(req_byte[win_id_c], PARITY_ODD);
          gnt_d         = win_id_c;
          tx_send_d     = 1'b1;
          cnt_d         = '0;
          state_d       = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tx.tx_done) begin
          tx_send_d = 1'b0;
          state_d   = ST_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tx_send_d = 1'b0;
          abort_d   = 1'b1;
          ack_d     = NUM_REQ'(1) << gnt_q;
          err_d     = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_RELEASE: begin
        if (!tx.tx_done) begin
          ack_d   = NUM_REQ'(1) << gnt_q;
          err_d   = abort_q;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = gnt_q;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign tx.tx_send   = tx_send_q;
  assign tx.tx_data   = word_q.data;
  assign tx.tx_parity = word_q.parity;
  assign req_ack      = ack_q;
  assign req_err      = err_q;
  assign gnt_id       = gnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: even-parity 4-requester instance plus an odd-parity instance.
module tb_uart_tx_sched;

  import uart_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int TX_LAT  = UART_FRAME_BITS + 2;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       par;
    logic       err;
  } exp_t;

  logic        baud_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        req_err;
  logic [1:0]  gnt_id;
  logic        busy;

  logic [1:0]  req_valid1;
  logic [15:0] req_data1;
  logic [1:0]  req_ack1;
  logic        req_err1;
  logic [0:0]  gnt_id1;
  logic        busy1;

  uart_tx_sched_if tx0 ();
  uart_tx_sched_if tx1 ();

  uart_tx_sched #(.NUM_REQ(4), .PARITY_ODD(1'b0), .TIMEOUT_CYC(TIMEOUT)) dut (
    .baud_clk (baud_clk), .rst_n (rst_n), .req_valid (req_valid), .req_data (req_data),
    .req_ack (req_ack), .req_err (req_err), .tx (tx0), .gnt_id (gnt_id), .busy (busy)
  );

  uart_tx_sched #(.NUM_REQ(2), .PARITY_ODD(1'b1), .TIMEOUT_CYC(TIMEOUT)) dut_odd (
    .baud_clk (baud_clk), .rst_n (rst_n), .req_valid (req_valid1), .req_data (req_data1),
    .req_ack (req_ack1), .req_err (req_err1), .tx (tx1), .gnt_id (gnt_id1), .busy (busy1)
  );

  always #5 baud_clk = ~baud_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q [$];
  int   remaining [4];

  bit   model_force = 1'b0;
  bit   model_never = 1'b0;
  int   model_hold  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic even_par(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return n[0];
  endfunction

  task automatic push_exp(input int id, input logic [7:0] b, input logic err);
    exp_t e;
    e.id = id; e.data = b; e.par = even_par(b); e.err = err;
    exp_q.push_back(e);
  endtask

  // TX stage model: done after TX_LAT send cycles, held model_hold cycles after send drops.
  int tx_cnt = 0;
  int hold_cnt = 0;
  always @(negedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx0.tx_done = 1'b0; tx_cnt = 0; hold_cnt = 0;
    end else if (model_force) begin
      tx0.tx_done = 1'b1;
    end else if (tx0.tx_send) begin
      hold_cnt = 0;
      if (!model_never && !tx0.tx_done) begin
        tx_cnt++;
        if (tx_cnt >= TX_LAT) tx0.tx_done = 1'b1;
      end
    end else begin
      tx_cnt = 0;
      if (tx0.tx_done) begin
        if (hold_cnt >= model_hold) begin tx0.tx_done = 1'b0; hold_cnt = 0; end
        else hold_cnt++;
      end
    end
  end

  // Monitor: grant/data checks, send length, release wait, ack pop against scoreboard.
  logic       send_prev = 1'b0, done_prev = 1'b0, ack_prev = 1'b0;
  int         send_len = 0;
  logic [8:0] cur_word;
  always begin
    @(negedge baud_clk);
    #2;
    if (!rst_n) begin
      send_prev = 1'b0; done_prev = 1'b0; ack_prev = 1'b0; send_len = 0;
    end else begin
      if (tx0.tx_send && !send_prev) begin
        if (exp_q.size() == 0) check("grant_unexpected", 32'(gnt_id), 32'hFFFF_FFFF);
        else begin
          check("gnt_id", 32'(gnt_id), 32'(exp_q[0].id));
          check("tx_data", 32'(tx0.tx_data), 32'(exp_q[0].data));
          check("tx_parity", 32'(tx0.tx_parity), 32'(exp_q[0].par));
        end
        cur_word = {tx0.tx_data, tx0.tx_parity};
      end
      if (tx0.tx_send && send_prev)
        check("data_stable", 32'({tx0.tx_data, tx0.tx_parity}), 32'(cur_word));
      if (tx0.tx_send) send_len++;
      if (!tx0.tx_send && send_prev) begin
        if (exp_q.size() > 0)
          check("send_len", 32'(send_len), 32'(exp_q[0].err ? TIMEOUT : TX_LAT));
        send_len = 0;
      end
      if (busy && !tx0.tx_send && req_ack == 4'b0)
        check("release_wait", 32'(done_prev), 32'd1);
      if (req_ack != 4'b0) begin
        if (exp_q.size() == 0) check("ack_unexpected", 32'(req_ack), 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_vec", 32'(req_ack), 32'(4'(1) << e.id));
          check("ack_err", 32'(req_err), 32'(e.err));
          check("ack_busy", 32'(busy), 32'd1);
          if (!e.err) check("ack_done_low", 32'(done_prev), 32'd0);
        end
      end else begin
        check("err_idle", 32'(req_err), 32'd0);
      end
      if (ack_prev) check("ack_width", 32'(req_ack), 32'd0);
      done_prev = tx0.tx_done;
      send_prev = tx0.tx_send;
      ack_prev  = |req_ack;
    end
  end

  // Drive producers until every pending byte is acked, then confirm the scoreboard drained.
  task automatic run_until_idle(input int budget);
    int  n = 0;
    bit  fin = 1'b0;
    while (!fin) begin
      @(negedge baud_clk);
      for (int i = 0; i < 4; i++) begin
        if (req_ack[i]) begin
          if (remaining[i] > 0) remaining[i]--;
          if (remaining[i] == 0) req_valid[i] = 1'b0;
        end
      end
      if (remaining[0] + remaining[1] + remaining[2] + remaining[3] == 0 && !busy) fin = 1'b1;
      n++;
      if (!fin && n > budget) begin
        check("wait_budget", 32'(n), 32'(budget));
        fin = 1'b1;
      end
    end
    repeat (2) @(negedge baud_clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_req(input int id, input logic [7:0] b, input int cnt);
    req_data[8*id +: 8] = b;
    req_valid[id]       = 1'b1;
    remaining[id]       = cnt;
  endtask

  // Odd-parity instance: hand-driven TX handshake.
  task automatic odd_xfer(input int id, input logic [7:0] b, input logic par);
    int n;
    req_data1 = '0;
    req_data1[8*id +: 8] = b;
    req_valid1 = 2'(1) << id;
    n = 0;
    while (!tx1.tx_send && n < 20) begin @(negedge baud_clk); n++; end
    check("odd_send", 32'(tx1.tx_send), 32'd1);
    check("odd_data", 32'(tx1.tx_data), 32'(b));
    check("odd_parity", 32'(tx1.tx_parity), 32'(par));
    repeat (4) @(negedge baud_clk);
    tx1.tx_done = 1'b1;
    n = 0;
    while (tx1.tx_send && n < 20) begin @(negedge baud_clk); n++; end
    check("odd_drop", 32'(tx1.tx_send), 32'd0);
    tx1.tx_done = 1'b0;
    n = 0;
    while (req_ack1 == 2'b0 && n < 10) begin @(negedge baud_clk); n++; end
    check("odd_ack", 32'(req_ack1), 32'(2'(1) << id));
    check("odd_err", 32'(req_err1), 32'd0);
    req_valid1 = '0;
    repeat (2) @(negedge baud_clk);
  endtask

  initial begin
    int n;
    req_valid = '0; req_data = '0; req_valid1 = '0; req_data1 = '0;
    tx1.tx_done = 1'b0;
    for (int i = 0; i < 4; i++) remaining[i] = 0;
    repeat (3) @(negedge baud_clk);
    check("rst_send", 32'(tx0.tx_send), 32'd0);
    check("rst_data", 32'(tx0.tx_data), 32'd0);
    check("rst_parity", 32'(tx0.tx_parity), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_gnt", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Leftover done holds the block in IDLE even with requests pending.
    model_force = 1'b1;
    @(negedge baud_clk);
    push_exp(0, 8'h10, 1'b0); push_exp(1, 8'h11, 1'b0); push_exp(2, 8'h12, 1'b0);
    push_exp(3, 8'h13, 1'b0); push_exp(0, 8'h10, 1'b0);
    start_req(0, 8'h10, 2); start_req(1, 8'h11, 1); start_req(2, 8'h12, 1); start_req(3, 8'h13, 1);
    repeat (4) @(negedge baud_clk);
    check("done_blocks_busy", 32'(busy), 32'd0);
    check("done_blocks_send", 32'(tx0.tx_send), 32'd0);
    model_force = 1'b0;
    run_until_idle(200);

    // Sticky done on requester 1.
    model_hold = 3;
    push_exp(1, 8'h3C, 1'b0);
    start_req(1, 8'h3C, 1);
    run_until_idle(60);
    model_hold = 0;

    // Timeout on requester 3.
    model_never = 1'b1;
    push_exp(3, 8'hFF, 1'b1);
    start_req(3, 8'hFF, 1);
    run_until_idle(120);
    model_never = 1'b0;

    // Single requests on requester 0; data change after grant is ignored.
    push_exp(0, 8'hA5, 1'b0);
    start_req(0, 8'hA5, 1);
    repeat (3) @(negedge baud_clk);
    req_data[7:0] = 8'h00;
    run_until_idle(60);
    push_exp(0, 8'h07, 1'b0);
    start_req(0, 8'h07, 1);
    run_until_idle(60);

    // Reset mid-SEND on requester 2, then requester 0 must win first.
    push_exp(2, 8'h55, 1'b0);
    start_req(2, 8'h55, 1);
    n = 0;
    while (!tx0.tx_send && n < 10) begin @(negedge baud_clk); n++; end
    check("pre_rst_send", 32'(tx0.tx_send), 32'd1);
    repeat (3) @(negedge baud_clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_send", 32'(tx0.tx_send), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(req_ack), 32'd0);
    exp_q.delete();
    req_valid[0] = 1'b1; req_data[7:0] = 8'h5A;
    repeat (2) @(negedge baud_clk);
    check("midrst_ack_hold", 32'(req_ack), 32'd0);
    push_exp(0, 8'h5A, 1'b0); push_exp(2, 8'h55, 1'b0);
    remaining[0] = 1; remaining[2] = 1;
    rst_n = 1'b1;
    run_until_idle(80);

    // Odd parity instance.
    odd_xfer(0, 8'h07, 1'b0);
    odd_xfer(1, 8'h03, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART serial transmitter among NUM_REQ byte producers. It picks a requester, latches its byte and computes the parity bit. It then runs the transmitter's send/done handshake: hold send until done, drop send, wait for done to clear. Finally it acknowledges the requester. A watchdog aborts a transfer if the transmitter never reports done. The block sits between the producers and the parallel-to-serial TX stage, clocked on the same baud clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity over the 8 data bits
TIMEOUT_CYC, 64, max baud_clk cycles in SEND before abort (must be >= 16; a frame takes 13 cycles plus handshake)

Ports:
baud_clk  in  1  sole clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte-pending; held until matching req_ack
req_data  in  8*NUM_REQ  flat bytes, requester i at [8i+7:8i]
req_ack  out  NUM_REQ  one-cycle one-hot pulse: transfer for requester i finished
req_err  out  1  one-cycle pulse coincident with req_ack when the transfer timed out
tx_send  out  1  send request to TX stage
tx_data  out  8  byte to TX stage, stable for whole send assertion
tx_parity  out  1  parity bit to TX stage, stable with tx_data
tx_done  in  1  TX stage done flag; high from frame end until send is dropped
gnt_id  out  clog2(NUM_REQ)  index of current/last granted requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE; tx_send=0, tx_data=0, tx_parity=0, req_ack=0, req_err=0, gnt_id=0, busy=0, timeout counter=0, RR pointer=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, SEND, RELEASE, ACK.
- IDLE: if tx_done=1 (TX stage still busy from before reset), stay in IDLE.
- IDLE, otherwise: if any req_valid, choose the winner by round-robin, searching from pointer+1 upward with wrap. Register tx_data=winner byte, gnt_id=winner, and tx_parity = XOR of the byte, XOR PARITY_ODD. Set tx_send=1, clear the counter, go to SEND. tx_send is therefore high one cycle after valid is sampled.
- SEND: tx_send=1, counter increments each cycle.
  - If tx_done=1: tx_send<=0, go to RELEASE.
  - Else, if counter==TIMEOUT_CYC-1: tx_send<=0, set the abort flag, go to ACK.
- RELEASE: tx_send=0; stay until tx_done=0, then go to ACK.
- ACK (exactly 1 cycle):
  - req_ack[gnt_id]=1; req_err=abort flag.
  - pointer<=gnt_id; clear the abort flag; go to IDLE.
  - Back-to-back requests re-arbitrate in the following IDLE cycle.
- tx_data and tx_parity change only on the IDLE->SEND transition. Producer data changes after grant are ignored.
- Requester dropping req_valid after grant: the transfer still completes and req_ack is still pulsed.
- Requests arriving during a transfer are held off; no queueing beyond req_valid.
- Fairness: with all NUM_REQ requesters continuously valid, grants go 0,1,2,3,0,...
- busy=1 in SEND, RELEASE and ACK.
- Reset asserted mid-transfer: everything returns to reset values immediately, tx_send drops asynchronously, and no ack is issued.
- Counter width is clog2(TIMEOUT_CYC+1); it never wraps because it is cleared on entry to SEND.

Decomposition:
- Shared package uart_pkg:
  - state enum for the four states
  - UART_FRAME_BITS=11 constant
  - parity function (byte, odd) -> bit
- Sub-module uart_rr_arb: combinational round-robin pick.
  - Inputs: req vector and pointer.
  - Outputs: winner index and any-valid.
  - Parameterised by NUM_REQ.
- The FSM, counter and registers stay in uart_tx_sched.

Test Plan:
- Single request: req_valid=4'b0001, req_data[7:0]=8'hA5, TX model raises tx_done 13 cycles after send. Expect: tx_data=8'hA5, tx_parity=0 (even), tx_send held until done, then req_ack=4'b0001 for 1 cycle, req_err=0.
- Odd parity: PARITY_ODD=1, byte 8'h07. Expect tx_parity=0. Byte 8'h03 -> tx_parity=1.
- All four requesters valid continuously, bytes 8'h10..8'h13. Expect acks in order 0,1,2,3,0 and tx_data sequence 10,11,12,13,10.
- Sticky done: TX model holds tx_done=1 for 3 cycles after send drops. Expect the block stays in RELEASE with tx_send=0, and req_ack fires only in the cycle after tx_done falls.
- Timeout: TX model never raises tx_done, TIMEOUT_CYC=64. Expect tx_send to drop after 64 cycles in SEND, then req_ack[i] and req_err both pulse for 1 cycle.
- Reset mid-SEND: assert rst_n=0 while tx_send=1. Expect tx_send=0 and busy=0 immediately, no req_ack. After release, requester 0 wins first.
